// File: rtl/ir_index_emulator.sv
// Synthetic IR index-pulse source that ramps the revolution period geometrically toward a target.
// Optional build macro IR_BOUNCE_EN adds a 1,0,1,0 contact-bounce prefix to every pulse.
`timescale 1ns/1ps

module ir_index_emulator #(
    parameter int PERIOD_WIDTH = 25,
    parameter int START_PERIOD = 20_000_000,
    parameter int PULSE_CYCLES = 16,
    parameter int RAMP_SHIFT   = 3
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    enable_in,
    input  logic [PERIOD_WIDTH-1:0] target_period_in,
    output logic                    ir_tripped_out,
    output logic                    locked_out,
    output logic [15:0]             rev_count_out,
    output logic [PERIOD_WIDTH-1:0] cur_period_out
);

    localparam logic [PERIOD_WIDTH-1:0] START_P = PERIOD_WIDTH'(START_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] PULSE_P = PERIOD_WIDTH'(PULSE_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] MIN_TGT = PERIOD_WIDTH'(2 * PULSE_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] ONE     = PERIOD_WIDTH'(1);

`ifdef IR_BOUNCE_EN
    if (PULSE_CYCLES < 6) begin : g_pulse_too_short
        $error("IR_BOUNCE_EN needs PULSE_CYCLES >= 6");
    end
`endif

    typedef enum logic [1:0] {IDLE, SPINUP, RUN} state_t;

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] phase_q, phase_d;
    logic [PERIOD_WIDTH-1:0] cur_q, cur_d;
    logic [15:0]             rev_q, rev_d;
    logic                    ir_q, ir_d;
    logic [PERIOD_WIDTH-1:0] tgt, diff, step, ramp_period;
    logic                    wrap, bounce_gap;

    // Clamp keeps the low time at least as long as the pulse itself.
    assign tgt  = (target_period_in < MIN_TGT) ? MIN_TGT : target_period_in;
    assign wrap = (phase_q == cur_q - ONE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        diff        = '0;
        ramp_period = tgt;
        if (cur_q >= tgt) begin
            diff = cur_q - tgt;
        end else begin
            diff = tgt - cur_q;
        end
        step = diff >> RAMP_SHIFT;
        if (step != '0) begin
            ramp_period = (cur_q > tgt) ? (cur_q - step) : (cur_q + step);
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cur_d   = cur_q;
        rev_d   = rev_q;
        if (!enable_in) begin
            state_d = IDLE;
            phase_d = '0;
            cur_d   = START_P;
            rev_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SPINUP;
                    phase_d = '0;
                end
                SPINUP, RUN: begin
                    if (wrap) begin
                        phase_d = '0;
                        rev_d   = rev_q + 16'd1;
                        cur_d   = ramp_period;
                        state_d = (ramp_period == tgt) ? RUN : SPINUP;
                    end else begin
                        phase_d = phase_q + ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef IR_BOUNCE_EN
    assign bounce_gap = (phase_d == ONE) || (phase_d == PERIOD_WIDTH'(3));
`else
    assign bounce_gap = 1'b0;
`endif

    // Output is decided from the next phase so the pulse rises on the enable/wrap edge itself.
    assign ir_d = (state_d != IDLE) && (phase_d < PULSE_P) && !bounce_gap;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            phase_q <= '0;
            cur_q   <= START_P;
            rev_q   <= '0;
            ir_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            phase_q <= phase_d;
            cur_q   <= cur_d;
            rev_q   <= rev_d;
            ir_q    <= ir_d;
        end
    end

    assign ir_tripped_out = ir_q;
    assign locked_out     = (state_q == RUN);
    assign rev_count_out  = rev_q;
    assign cur_period_out = cur_q;

endmodule

// File: tb/tb_ir_index_emulator.sv
// Self-checking bench for ir_index_emulator: table-driven ramp profiles, hand-written corner
// sequences and randomized enable/target traffic against a per-cycle reference model.
`timescale 1ns/1ps

module tb_ir_index_emulator;

    localparam int PW    = 25;
    localparam int START = 100;
    localparam int RS    = 1;
`ifdef IR_BOUNCE_EN
    localparam int P      = 8;
    localparam bit BOUNCE = 1'b1;
`else
    localparam int P      = 4;
    localparam bit BOUNCE = 1'b0;
`endif

    logic          clk_in   = 1'b0;
    logic          rst_n_in = 1'b1;
    logic          enable_in = 1'b0;
    logic [PW-1:0] target_period_in = '0;
    logic          ir_tripped_out;
    logic          locked_out;
    logic [15:0]   rev_count_out;
    logic [PW-1:0] cur_period_out;

    ir_index_emulator #(
        .PERIOD_WIDTH(PW),
        .START_PERIOD(START),
        .PULSE_CYCLES(P),
        .RAMP_SHIFT  (RS)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .enable_in       (enable_in),
        .target_period_in(target_period_in),
        .ir_tripped_out  (ir_tripped_out),
        .locked_out      (locked_out),
        .rev_count_out   (rev_count_out),
        .cur_period_out  (cur_period_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one revolution at a time, period ramped by integer division.
    int m_phase, m_period, m_rev, mt, md, ms;
    bit m_on, m_lock;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in || !enable_in) begin
            m_on = 0; m_phase = 0; m_period = START; m_rev = 0; m_lock = 0;
        end else if (!m_on) begin
            m_on = 1; m_phase = 0;
        end else if (m_phase == m_period - 1) begin
            mt = (int'(target_period_in) < 2 * P) ? 2 * P : int'(target_period_in);
            md = (m_period > mt) ? m_period - mt : mt - m_period;
            ms = md / (2 ** RS);
            if (ms == 0)            m_period = mt;
            else if (m_period > mt) m_period = m_period - ms;
            else                    m_period = m_period + ms;
            m_rev   = (m_rev + 1) % 65536;
            m_lock  = (m_period == mt);
            m_phase = 0;
        end else begin
            m_phase++;
        end
    end

    function automatic bit model_ir();
        return m_on && (m_phase < P) && !(BOUNCE && (m_phase == 1 || m_phase == 3));
    endfunction

    always @(negedge clk_in) begin
        logic [63:0] a, e;
        a = {21'd0, ir_tripped_out, locked_out, rev_count_out, cur_period_out};
        e = {21'd0, model_ir(), m_lock, m_rev[15:0], m_period[PW-1:0]};
        check("cycle ir/locked/rev/period", a, e);
    end

    // Wrap log: timestamps of rev_count increments, used to measure pulse spacing.
    int          cyc = 0;
    int          wrap_t[$];
    bit          wrap_l[$];
    logic [15:0] prev_rev = '0;

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (rev_count_out !== prev_rev && rev_count_out != 16'd0) begin
            wrap_t.push_back(cyc);
            wrap_l.push_back(locked_out);
        end
        prev_rev = rev_count_out;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic start_run(input int tgt, output int t0);
        enable_in = 1'b0;
        tick(2);
        target_period_in = PW'(tgt);
        wrap_t.delete();
        wrap_l.delete();
        enable_in = 1'b1;
        t0 = cyc + 1;
    endtask

    task automatic wait_wraps(input int n, input string name, output bit ok);
        int c = 0;
        while (wrap_t.size() < n && c < 4000) begin
            tick(1);
            c++;
        end
        ok = (wrap_t.size() >= n);
        check({name, " wrap timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_phase(input int ph, input string name);
        int c = 0;
        bit found = 0;
        while (!found && c < 4000) begin
            tick(1);
            c++;
            found = m_on && (m_phase == ph);
        end
        check({name, " phase timeout"}, 64'(found), 64'd1);
    endtask

    typedef struct {
        int target;
        int n;
        int sp[10];
        int lock_wrap;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int t0, prev, r;
        bit ok;

        vecs[0] = '{64, 9, '{100, 82, 73, 69, 67, 66, 65, 64, 64, 0}, 7};
        vecs[1] = '{100, 3, '{100, 100, 100, 0, 0, 0, 0, 0, 0, 0}, 1};
`ifdef IR_BOUNCE_EN
        vecs[2] = '{3, 10, '{100, 58, 37, 27, 22, 19, 18, 17, 16, 16}, 8};
`else
        vecs[2] = '{3, 10, '{100, 54, 31, 20, 14, 11, 10, 9, 8, 8}, 8};
`endif

        #1 rst_n_in = 1'b0;
        #1;
        check("reset ir", 64'(ir_tripped_out), 64'd0);
        check("reset locked", 64'(locked_out), 64'd0);
        check("reset rev", 64'(rev_count_out), 64'd0);
        check("reset period", 64'(cur_period_out), 64'(START));
        tick(3);
        rst_n_in = 1'b1;
        tick(2);

        for (int v = 0; v < 3; v++) begin
            start_run(vecs[v].target, t0);
            wait_wraps(vecs[v].n, $sformatf("vec%0d", v), ok);
            if (ok) begin
                prev = t0;
                for (int w = 0; w < vecs[v].n; w++) begin
                    check($sformatf("vec%0d spacing %0d", v, w), 64'(wrap_t[w] - prev), 64'(vecs[v].sp[w]));
                    check($sformatf("vec%0d locked at wrap %0d", v, w + 1), 64'(wrap_l[w]),
                          64'(w + 1 >= vecs[v].lock_wrap));
                    prev = wrap_t[w];
                end
            end
        end

        // Retarget 64 -> 80 in the middle of a locked revolution.
        start_run(64, t0);
        wait_wraps(8, "lock64", ok);
        check("lock64 locked", 64'(locked_out), 64'd1);
        tick(10);
        target_period_in = PW'(80);
        wait_wraps(14, "retarget", ok);
        if (ok) begin
            int exp_sp[6] = '{64, 72, 76, 78, 79, 80};
            bit exp_lk[6] = '{0, 0, 0, 0, 1, 1};
            for (int w = 0; w < 6; w++) begin
                check($sformatf("retarget spacing %0d", w), 64'(wrap_t[8 + w] - wrap_t[7 + w]), 64'(exp_sp[w]));
                check($sformatf("retarget locked %0d", w), 64'(wrap_l[8 + w]), 64'(exp_lk[w]));
            end
        end

        // Disable on the second cycle of a pulse, then re-enable from scratch.
        wait_phase(1, "disable");
        enable_in = 1'b0;
        tick(1);
        check("disable ir", 64'(ir_tripped_out), 64'd0);
        check("disable rev", 64'(rev_count_out), 64'd0);
        check("disable period", 64'(cur_period_out), 64'(START));
        start_run(80, t0);
        wait_wraps(1, "reenable", ok);
        if (ok) check("reenable first spacing", 64'(wrap_t[0] - t0), 64'(START));

        // Pulse shape over one revolution start.
        wait_phase(0, "shape");
        for (int i = 0; i <= P; i++) begin
            check($sformatf("shape cycle %0d", i), 64'(ir_tripped_out),
                  64'((i < P) && !(BOUNCE && (i == 1 || i == 3))));
            tick(1);
        end

        // Asynchronous reset in the middle of a pulse.
        wait_phase(2, "async reset");
        check("pre-reset ir", 64'(ir_tripped_out), 64'd1);
        #2 rst_n_in = 1'b0;
        #1;
        check("async reset ir", 64'(ir_tripped_out), 64'd0);
        check("async reset period", 64'(cur_period_out), 64'(START));
        tick(2);
        rst_n_in = 1'b1;

        // Randomized enable/target traffic against the model.
        enable_in = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            tick(1);
            r = int'($urandom_range(0, 999));
            if (r < 4)                      target_period_in = PW'($urandom_range(0, 150));
            else if (r < 6)                 target_period_in = PW'($urandom_range(2 * P - 2, 2 * P + 2));
            else if (r < 8)                 enable_in = ~enable_in;
            else if (!enable_in && r < 200) enable_in = 1'b1;
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
